// File: rtl/alu_result_checker.sv
// alu_result_checker: response-side scoreboard for yAlu. Recomputes the golden
// result of every accepted (a, b, op, z, zero) transaction through a two-stage
// pipe and keeps saturating pass/fail/illegal counts plus a sticky capture of
// the first mismatching transaction.
module alu_result_checker #(
    parameter int unsigned W            = 32,
    parameter int unsigned NUM_TXN      = 100,
    parameter int unsigned CNT_W        = 16,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [2:0]       in_op,
    input  logic [W-1:0]     in_z,
    input  logic             in_zero,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             ff_valid,
    output logic [2:0]       ff_op,
    output logic [W-1:0]     ff_exp,
    output logic [W-1:0]     ff_act
);
    localparam int unsigned      ACC_W    = $clog2(NUM_TXN + 1);
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(NUM_TXN);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [ACC_W-1:0] accepted;
    logic [ACC_W-1:0] accepted_n;

    // stage 0: captured transaction
    logic             s0_valid;
    logic [W-1:0]     s0_a;
    logic [W-1:0]     s0_b;
    logic [2:0]       s0_op;
    logic [W-1:0]     s0_z;
    logic             s0_zero;

    // stage 1: golden result alongside the values under test
    logic             s1_valid;
    logic             s1_illegal;
    logic [2:0]       s1_op;
    logic [W-1:0]     s1_exp;
    logic             s1_exp_zero;
    logic [W-1:0]     s1_z;
    logic             s1_zero;

    logic             xfer_c;
    logic             restart_c;
    logic             illegal_c;
    logic [W-1:0]     exp_c;
    logic             ready_n;
    logic [CNT_W-1:0] pass_n;
    logic [CNT_W-1:0] fail_n;
    logic [CNT_W-1:0] illegal_n;
    logic             ffv_n;
    logic [2:0]       ff_op_n;
    logic [W-1:0]     ff_exp_n;
    logic [W-1:0]     ff_act_n;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Golden ALU result for the captured transaction; add/sub wrap mod 2^W.
    always_comb begin
        exp_c     = '0;
        illegal_c = 1'b0;
        case (s0_op)
            OP_AND:  exp_c = s0_a & s0_b;
            OP_OR:   exp_c = s0_a | s0_b;
            OP_ADD:  exp_c = s0_a + s0_b;
            OP_SUB:  exp_c = s0_a - s0_b;
            OP_SLT:  exp_c = W'($signed(s0_a) < $signed(s0_b));
            default: illegal_c = 1'b1;
        endcase
    end

    // Next-state, counter update and first-fail capture.
    always_comb begin
        state_n    = state;
        accepted_n = accepted;
        pass_n     = pass_cnt;
        fail_n     = fail_cnt;
        illegal_n  = illegal_cnt;
        ffv_n      = ff_valid;
        ff_op_n    = ff_op;
        ff_exp_n   = ff_exp;
        ff_act_n   = ff_act;
        restart_c  = 1'b0;
        xfer_c     = in_valid && in_ready;

        if (s1_valid) begin
            if (s1_illegal) begin
                illegal_n = sat_inc(illegal_cnt);
            end else if ((s1_z == s1_exp) && (s1_zero == s1_exp_zero)) begin
                pass_n = sat_inc(pass_cnt);
            end else begin
                fail_n = sat_inc(fail_cnt);
                if (!ff_valid) begin
                    ffv_n    = 1'b1;
                    ff_op_n  = s1_op;
                    ff_exp_n = s1_exp;
                    ff_act_n = s1_z;
                end
            end
        end

        if (xfer_c) begin
            accepted_n = accepted + ACC_W'(1);
        end

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n   = S_RUN;
                    restart_c = 1'b1;
                end
            end
            S_RUN: begin
                // a run halted by a mismatch can only be left by start or reset
                if (start && STOP_ON_FAIL && ff_valid) begin
                    restart_c = 1'b1;
                end else if ((accepted == ACC_LAST) && !s0_valid && !s1_valid &&
                             !(STOP_ON_FAIL && ff_valid)) begin
                    state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (restart_c) begin
            accepted_n = '0;
            pass_n     = '0;
            fail_n     = '0;
            illegal_n  = '0;
            ffv_n      = 1'b0;
            ff_op_n    = '0;
            ff_exp_n   = '0;
            ff_act_n   = '0;
        end

        ready_n = (state_n == S_RUN) && (accepted_n < ACC_LAST) && !(STOP_ON_FAIL && ffv_n);
    end

    // Control state, counters, captures and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            accepted    <= '0;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            illegal_cnt <= '0;
            ff_valid    <= 1'b0;
            ff_op       <= '0;
            ff_exp      <= '0;
            ff_act      <= '0;
            s0_valid    <= 1'b0;
            s1_valid    <= 1'b0;
        end else begin
            state       <= state_n;
            accepted    <= accepted_n;
            in_ready    <= ready_n;
            busy        <= (state_n == S_RUN);
            done        <= (state_n == S_DONE);
            pass_cnt    <= pass_n;
            fail_cnt    <= fail_n;
            illegal_cnt <= illegal_n;
            ff_valid    <= ffv_n;
            ff_op       <= ff_op_n;
            ff_exp      <= ff_exp_n;
            ff_act      <= ff_act_n;
            s0_valid    <= xfer_c && !restart_c;
            s1_valid    <= s0_valid && !restart_c;
        end
    end

    // Pipeline payload; qualified by the valid bits above.
    always_ff @(posedge clk) begin
        if (xfer_c) begin
            s0_a    <= in_a;
            s0_b    <= in_b;
            s0_op   <= in_op;
            s0_z    <= in_z;
            s0_zero <= in_zero;
        end
        if (s0_valid) begin
            s1_illegal  <= illegal_c;
            s1_op       <= s0_op;
            s1_exp      <= exp_c;
            s1_exp_zero <= (exp_c == '0);
            s1_z        <= s0_z;
            s1_zero     <= s0_zero;
        end
    end

endmodule
